// File: rtl/axis_sram_stager.sv
// axis_sram_stager: packs AXIS beats into wide SRAM words on load and unpacks them on drain, under AXI-Lite control
module axis_sram_stager #(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32,
   parameter int pRAM_WIDTH  = 64,
   parameter int pRAM_AW     = 10
) (
   input  logic                   axi_clk,
   input  logic                   axi_reset_n,
   input  logic                   awvalid,
   input  logic [pADDR_WIDTH-1:0] awaddr,
   input  logic                   wvalid,
   input  logic [pDATA_WIDTH-1:0] wdata,
   output logic                   awready,
   output logic                   wready,
   input  logic                   arvalid,
   input  logic [pADDR_WIDTH-1:0] araddr,
   input  logic                   rready,
   output logic                   arready,
   output logic                   rvalid,
   output logic [pDATA_WIDTH-1:0] rdata,
   input  logic                   ss_tvalid,
   input  logic [pDATA_WIDTH-1:0] ss_tdata,
   input  logic                   ss_tlast,
   output logic                   ss_tready,
   output logic                   sm_tvalid,
   output logic [pDATA_WIDTH-1:0] sm_tdata,
   output logic                   sm_tlast,
   input  logic                   sm_tready,
   output logic                   ram_en,
   output logic                   ram_we,
   output logic [pRAM_AW-1:0]     ram_adr,
   output logic [pRAM_WIDTH-1:0]  ram_d,
   input  logic [pRAM_WIDTH-1:0]  ram_q
);
   localparam int K = pRAM_WIDTH / pDATA_WIDTH;
   localparam int LW = K > 1 ? $clog2(K) : 1;
   localparam logic [LW-1:0] LAST_LANE = LW'(K - 1);
   localparam logic [pADDR_WIDTH-1:0] A_CTRL = pADDR_WIDTH'('h0);
   localparam logic [pADDR_WIDTH-1:0] A_STATUS = pADDR_WIDTH'('h4);
   localparam logic [pADDR_WIDTH-1:0] A_LEN = pADDR_WIDTH'('h8);
   localparam logic [pADDR_WIDTH-1:0] A_WCNT = pADDR_WIDTH'('hC);

   typedef enum logic [2:0] {IDLE, LOAD, RD_REQ, RD_WAIT, EMIT} state_t;

   state_t                 state, state_d;
   logic [pRAM_AW-1:0]     addr, addr_d, len, wcnt;
   logic [LW-1:0]          lane, lane_d;
   logic [pRAM_WIDTH-1:0]  word, word_d;
   logic                   load_done, drain_done, early_tlast;
   logic                   set_load, set_drain, set_early, wcnt_we;
   logic                   wr, start_load, start_drain, rd_go;
   logic [2:0]             clr;
   logic [pDATA_WIDTH-1:0] rd_mux;
   logic                   unused_wdata;

   assign wr = awvalid & wvalid;
   assign awready = wr;
   assign wready = wr;
   assign start_load = wr && awaddr == A_CTRL && wdata[0];
   assign start_drain = wr && awaddr == A_CTRL && wdata[1];
   assign clr = wr && awaddr == A_STATUS ? wdata[3:1] : 3'b000;
   assign arready = !rvalid;
   assign rd_go = arvalid & !rvalid;
   assign unused_wdata = ^wdata[pDATA_WIDTH-1:pRAM_AW];
   assign rd_mux = araddr == A_STATUS ? pDATA_WIDTH'({early_tlast, drain_done, load_done, state == IDLE}) :
                   araddr == A_LEN    ? pDATA_WIDTH'(len) :
                   araddr == A_WCNT   ? pDATA_WIDTH'(wcnt) : '0;

   // read channel: capture the addressed register at arvalid, hold it until rready
   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         rvalid <= 1'b0;
         rdata  <= '0;
      end else if (rd_go) begin
         rvalid <= 1'b1;
         rdata  <= rd_mux;
      end else if (rready) begin
         rvalid <= 1'b0;
      end
   end

   // control registers; a sticky set in the same cycle as its W1C clear keeps the bit set
   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         len         <= '1;
         wcnt        <= '0;
         load_done   <= 1'b0;
         drain_done  <= 1'b0;
         early_tlast <= 1'b0;
      end else begin
         if (wr && awaddr == A_LEN && state == IDLE) len <= wdata[pRAM_AW-1:0];
         if (wcnt_we) wcnt <= addr;
         load_done   <= set_load | (load_done & ~clr[0]);
         drain_done  <= set_drain | (drain_done & ~clr[1]);
         early_tlast <= set_early | (early_tlast & ~clr[2]);
      end
   end

   // engine state: FSM, word address, lane index and the word being packed or unpacked
   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         state <= IDLE;
         addr  <= '0;
         lane  <= '0;
         word  <= '0;
      end else begin
         state <= state_d;
         addr  <= addr_d;
         lane  <= lane_d;
         word  <= word_d;
      end
   end

   // next state and datapath outputs; a load word is written on its last lane or on tlast
   always_comb begin
      state_d   = state;
      addr_d    = addr;
      lane_d    = lane;
      word_d    = word;
      set_load  = 1'b0;
      set_drain = 1'b0;
      set_early = 1'b0;
      wcnt_we   = 1'b0;
      ss_tready = 1'b0;
      sm_tvalid = 1'b0;
      sm_tdata  = '0;
      sm_tlast  = 1'b0;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_adr   = '0;
      ram_d     = '0;
      case (state)
         IDLE: if (start_load || start_drain) begin
            state_d = start_load ? LOAD : RD_REQ;
            addr_d  = '0;
            lane_d  = '0;
            word_d  = '0;
         end
         LOAD: begin
            ss_tready = 1'b1;
            if (ss_tvalid) begin
               word_d[lane*pDATA_WIDTH +: pDATA_WIDTH] = ss_tdata;
               lane_d = lane + 1'b1;
               if (ss_tlast || lane == LAST_LANE) begin
                  ram_en  = 1'b1;
                  ram_we  = 1'b1;
                  ram_adr = addr;
                  ram_d   = word_d;
                  word_d  = '0;
                  lane_d  = '0;
                  addr_d  = addr + 1'b1;
                  if (ss_tlast || addr == len) begin
                     state_d   = IDLE;
                     set_load  = 1'b1;
                     wcnt_we   = 1'b1;
                     set_early = ss_tlast && !(addr == len && lane == LAST_LANE);
                  end
               end
            end
         end
         RD_REQ: begin
            ram_en  = 1'b1;
            ram_adr = addr;
            state_d = RD_WAIT;
         end
         RD_WAIT: begin
            word_d  = ram_q;
            state_d = EMIT;
         end
         EMIT: begin
            sm_tvalid = 1'b1;
            sm_tdata  = word[lane*pDATA_WIDTH +: pDATA_WIDTH];
            sm_tlast  = lane == LAST_LANE && addr == len;
            if (sm_tready) begin
               lane_d = lane + 1'b1;
               if (lane == LAST_LANE) begin
                  lane_d    = '0;
                  addr_d    = addr + 1'b1;
                  state_d   = addr == len ? IDLE : RD_REQ;
                  set_drain = addr == len;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_axis_sram_stager.sv
// tb_axis_sram_stager: directed tests of load packing, drain unpacking, register access and reset abort
module tb_axis_sram_stager;
   localparam int AW = 12, DW = 32, RW = 64, RA = 10;

   logic          axi_clk = 1'b0, axi_reset_n = 1'b0;
   logic          awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, rready = 1'b1;
   logic [AW-1:0] awaddr = '0, araddr = '0;
   logic [DW-1:0] wdata = '0, rdata;
   logic          awready, wready, arready, rvalid;
   logic          ss_tvalid = 1'b0, ss_tlast = 1'b0, ss_tready;
   logic [DW-1:0] ss_tdata = '0, sm_tdata;
   logic          sm_tvalid, sm_tlast, sm_tready = 1'b0;
   logic          ram_en, ram_we;
   logic [RA-1:0] ram_adr;
   logic [RW-1:0] ram_d, ram_q = '0;
   logic [RW-1:0] mem [0:(1<<RA)-1];
   int            checks = 0, errors = 0;

   axis_sram_stager #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pRAM_WIDTH(RW), .pRAM_AW(RA)) dut (
      .axi_clk(axi_clk), .axi_reset_n(axi_reset_n),
      .awvalid(awvalid), .awaddr(awaddr), .wvalid(wvalid), .wdata(wdata),
      .awready(awready), .wready(wready),
      .arvalid(arvalid), .araddr(araddr), .rready(rready),
      .arready(arready), .rvalid(rvalid), .rdata(rdata),
      .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
      .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready),
      .ram_en(ram_en), .ram_we(ram_we), .ram_adr(ram_adr), .ram_d(ram_d), .ram_q(ram_q)
   );

   always #5 axi_clk = ~axi_clk;

   // single-port SRAM model with one-cycle read latency
   always @(posedge axi_clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_adr] <= ram_d;
         else ram_q <= mem[ram_adr];
      end
   end

   task automatic axil_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge axi_clk);
      awvalid = 1'b1; wvalid = 1'b1; awaddr = a; wdata = d;
      @(negedge axi_clk);
      awvalid = 1'b0; wvalid = 1'b0;
   endtask

   task automatic axil_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
      @(negedge axi_clk);
      arvalid = 1'b1; araddr = a; rready = 1'b1;
      @(negedge axi_clk);
      arvalid = 1'b0;
      d = rdata;
   endtask

   task automatic send_beat(input logic [DW-1:0] d, input logic last);
      @(negedge axi_clk);
      ss_tvalid = 1'b1; ss_tdata = d; ss_tlast = last;
      for (int i = 0; i < 20 && !ss_tready; i++) @(negedge axi_clk);
      if (!ss_tready) begin
         checks++; errors++;
         $display("FAIL load_accept_timeout beat=%h ss_tready=%b want 1", d, ss_tready);
      end
   endtask

   task automatic end_beats();
      @(negedge axi_clk);
      ss_tvalid = 1'b0; ss_tlast = 1'b0;
   endtask

   task automatic test_reset();
      logic [DW-1:0] d;
      repeat (2) @(negedge axi_clk);
      checks++;
      if ({arready, rvalid, awready, wready, ss_tready, sm_tvalid, sm_tlast, ram_en, ram_we} !== 9'b1_0000_0000) begin
         errors++;
         $display("FAIL reset_ctrl_outputs got %b want 100000000",
                  {arready, rvalid, awready, wready, ss_tready, sm_tvalid, sm_tlast, ram_en, ram_we});
      end
      checks++;
      if ({ram_adr, ram_d, sm_tdata, rdata} !== '0) begin
         errors++;
         $display("FAIL reset_data_outputs adr=%h d=%h sm=%h rd=%h want 0", ram_adr, ram_d, sm_tdata, rdata);
      end
      axi_reset_n = 1'b1;
      @(negedge axi_clk);
      arvalid = 1'b1; araddr = 12'h004;
      checks++;
      if (rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_early got %b want 0", rvalid); end
      @(negedge axi_clk);
      arvalid = 1'b0;
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h1) begin
         errors++; $display("FAIL reset_status rvalid=%b rdata=%h want 1/00000001", rvalid, rdata);
      end
      axil_read(12'h008, d);
      checks++;
      if (d !== 32'h3FF) begin errors++; $display("FAIL reset_len got %h want 000003ff", d); end
      axil_read(12'h00C, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL reset_wcnt got %h want 0", d); end
      axil_read(12'h010, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h want 0", d); end
   endtask

   task automatic test_load();
      logic [DW-1:0] d;
      logic [RW-1:0] e;
      axil_write(12'h008, 32'h3);
      axil_write(12'h000, 32'h1);
      for (int i = 1; i <= 8; i++) send_beat(DW'(i), 1'b0);
      end_beats();
      checks++;
      if (ss_tready !== 1'b0) begin errors++; $display("FAIL load_end_tready got %b want 0", ss_tready); end
      for (int i = 0; i < 4; i++) begin
         e = {DW'(2*i+2), DW'(2*i+1)};
         checks++;
         if (mem[i] !== e) begin errors++; $display("FAIL load_mem%0d got %h want %h", i, mem[i], e); end
      end
      axil_read(12'h004, d);
      checks++;
      if (d !== 32'h3) begin errors++; $display("FAIL load_status got %h want 00000003", d); end
      axil_read(12'h00C, d);
      checks++;
      if (d !== 32'h3) begin errors++; $display("FAIL load_wcnt got %h want 00000003", d); end
   endtask

   task automatic test_drain_backpressure();
      logic [DW-1:0] d, prev_d;
      logic          stalled;
      int            got;
      got = 0; stalled = 1'b0; prev_d = '0;
      axil_write(12'h000, 32'h2);
      for (int c = 0; c < 300 && got < 8; c++) begin
         sm_tready = c[0];
         if (sm_tvalid) begin
            if (stalled) begin
               checks++;
               if (sm_tdata !== prev_d) begin
                  errors++; $display("FAIL drain_stable got %h want %h", sm_tdata, prev_d);
               end
            end
            if (sm_tready) begin
               checks++;
               if (sm_tdata !== DW'(got + 1) || sm_tlast !== (got == 7)) begin
                  errors++;
                  $display("FAIL drain_beat%0d got %h/%b want %h/%b", got, sm_tdata, sm_tlast, DW'(got + 1), got == 7);
               end
               got++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1; prev_d = sm_tdata;
            end
         end
         @(negedge axi_clk);
      end
      sm_tready = 1'b0;
      checks++;
      if (got != 8 || sm_tvalid !== 1'b0) begin
         errors++; $display("FAIL drain_complete beats=%0d tvalid=%b want 8/0", got, sm_tvalid);
      end
      axil_read(12'h004, d);
      checks++;
      if (d !== 32'h7) begin errors++; $display("FAIL drain_status got %h want 00000007", d); end
   endtask

   task automatic test_read_hold_w1c();
      logic [DW-1:0] d;
      @(negedge axi_clk);
      arvalid = 1'b1; araddr = 12'h004; rready = 1'b0;
      @(negedge axi_clk);
      arvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({rvalid, arready, rdata} !== {1'b1, 1'b0, 32'h7}) begin
            errors++; $display("FAIL read_hold%0d got %b/%b/%h want 1/0/00000007", i, rvalid, arready, rdata);
         end
         @(negedge axi_clk);
      end
      rready = 1'b1;
      @(negedge axi_clk);
      checks++;
      if (rvalid !== 1'b0) begin errors++; $display("FAIL read_release got %b want 0", rvalid); end
      axil_write(12'h004, 32'h6);
      axil_read(12'h004, d);
      checks++;
      if (d !== 32'h1) begin errors++; $display("FAIL w1c_status got %h want 00000001", d); end
   endtask

   task automatic test_early_tlast();
      logic [DW-1:0] d;
      axil_write(12'h000, 32'h1);
      send_beat(32'hA, 1'b0);
      send_beat(32'hB, 1'b0);
      send_beat(32'hC, 1'b1);
      end_beats();
      checks++;
      if (ss_tready !== 1'b0) begin errors++; $display("FAIL early_tready got %b want 0", ss_tready); end
      checks++;
      if (mem[0] !== 64'h0000000B_0000000A) begin
         errors++; $display("FAIL early_mem0 got %h want 0000000b0000000a", mem[0]);
      end
      checks++;
      if (mem[1] !== 64'h00000000_0000000C) begin
         errors++; $display("FAIL early_mem1 got %h want 000000000000000c", mem[1]);
      end
      axil_read(12'h00C, d);
      checks++;
      if (d !== 32'h1) begin errors++; $display("FAIL early_wcnt got %h want 00000001", d); end
      axil_read(12'h004, d);
      checks++;
      if (d !== 32'hB) begin errors++; $display("FAIL early_status got %h want 0000000b", d); end
   endtask

   task automatic test_start_priority();
      logic [DW-1:0] d;
      axil_write(12'h004, 32'hE);
      axil_write(12'h000, 32'h3);
      checks++;
      if (ss_tready !== 1'b1 || ram_en !== 1'b0) begin
         errors++; $display("FAIL both_start_load tready=%b ram_en=%b want 1/0", ss_tready, ram_en);
      end
      axil_write(12'h000, 32'h2);
      checks++;
      if (ss_tready !== 1'b1 || sm_tvalid !== 1'b0 || ram_en !== 1'b0) begin
         errors++; $display("FAIL drain_ignored tready=%b tvalid=%b ram_en=%b want 1/0/0", ss_tready, sm_tvalid, ram_en);
      end
      axil_write(12'h008, 32'h0);
      axil_read(12'h008, d);
      checks++;
      if (d !== 32'h3) begin errors++; $display("FAIL len_locked got %h want 00000003", d); end
      axil_read(12'h004, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL busy_status got %h want 0", d); end
      send_beat(32'h55, 1'b1);
      end_beats();
      checks++;
      if (mem[0] !== 64'h55) begin errors++; $display("FAIL single_beat_mem got %h want 55", mem[0]); end
      axil_read(12'h004, d);
      checks++;
      if (d !== 32'hB) begin errors++; $display("FAIL single_beat_status got %h want 0000000b", d); end
   endtask

   task automatic test_reset_mid_drain();
      logic [DW-1:0] d;
      logic [DW-1:0] exp_beats [3];
      int            got;
      exp_beats = '{32'h55, 32'h0, 32'hC};
      got = 0;
      axil_write(12'h004, 32'hE);
      axil_write(12'h000, 32'h2);
      sm_tready = 1'b1;
      for (int c = 0; c < 100 && got < 3; c++) begin
         if (sm_tvalid) begin
            checks++;
            if (sm_tdata !== exp_beats[got]) begin
               errors++; $display("FAIL abort_beat%0d got %h want %h", got, sm_tdata, exp_beats[got]);
            end
            got++;
         end
         @(negedge axi_clk);
      end
      checks++;
      if (got != 3 || sm_tvalid !== 1'b1) begin
         errors++; $display("FAIL abort_pre beats=%0d tvalid=%b want 3/1", got, sm_tvalid);
      end
      axi_reset_n = 1'b0;
      #1;
      checks++;
      if ({sm_tvalid, ss_tready, ram_en} !== 3'b000) begin
         errors++; $display("FAIL abort_outputs got %b want 000", {sm_tvalid, ss_tready, ram_en});
      end
      sm_tready = 1'b0;
      @(negedge axi_clk);
      axi_reset_n = 1'b1;
      axil_read(12'h004, d);
      checks++;
      if (d !== 32'h1) begin errors++; $display("FAIL abort_status got %h want 00000001", d); end
      axil_read(12'h008, d);
      checks++;
      if (d !== 32'h3FF) begin errors++; $display("FAIL abort_len got %h want 000003ff", d); end
   endtask

   initial begin
      test_reset();
      test_load();
      test_drain_backpressure();
      test_read_hold_w1c();
      test_early_tlast();
      test_start_priority();
      test_reset_mid_drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
